mem_inspector: RTL and testbench

Post-run memory inspector for the MIPS core on Basys3. It sits downstream of the control unit's inference read port: it drives `infer`/`infer_addr`, captures `infer_data`, and shows the captured word in hex on the 4-digit seven-segment display. Debounced push-buttons step through word addresses, and a switch selects which half-word is shown. It is active only while the core reports halt.

---
 rtl/mem_inspector_if.sv | 9 +
 rtl/mem_inspector.sv | 194 +++++++++++++++++++
 tb/tb_mem_inspector.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_inspector_if.sv
// Read port between the inspector and the control unit's inference path.
interface mem_inspector_if;
  logic        infer;
  logic [9:0]  infer_addr;
  logic [31:0] infer_data;

  modport master (output infer, output infer_addr, input infer_data);
  modport slave  (input infer, input infer_addr, output infer_data);
endinterface

// File: rtl/mem_inspector.sv
// Post-halt memory inspector: debounced buttons step a word address, each step re-reads and shows the word in hex.
// Read-to-show latency READ_LATENCY+2 cycles; steps outside SHOW are dropped. Optional MEM_INSPECTOR_AUTOSCAN_EN adds a periodic auto-step.
module mem_inspector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int READ_LATENCY    = 2,
  parameter int REFRESH_BITS    = 18,
  parameter int ADDR_MAX        = 1023
) (
  input  logic                   fast_clk,
  input  logic                   rst_n,
  input  logic                   halted,
  input  logic                   btn_next,
  input  logic                   btn_prev,
  input  logic                   sw_half,
  mem_inspector_if.master        rd,
  output logic                   data_valid,
  output logic [6:0]             LED_out,
  output logic [3:0]             Anode_Activate
);

  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam int LW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);
  localparam logic [9:0] ADDR_TOP = 10'(ADDR_MAX);

  typedef enum logic [1:0] {IDLE, REQ, CAPTURE, SHOW} state_t;

  // Button path: index 0 = next, 1 = prev
  logic [1:0]     btn_raw;
  logic [1:0]     sync1, sync2;
  logic [1:0]     db_lvl, db_lvl_q;
  logic [DBW-1:0] db_cnt [2];
  logic           step_next, step_prev;

  assign btn_raw = {btn_prev, btn_next};

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign step_next = db_lvl[0] & ~db_lvl_q[0];
  assign step_prev = db_lvl[1] & ~db_lvl_q[1];

  state_t        state;
  logic          infer_r;
  logic [9:0]    addr_r;
  logic [31:0]   shown_word;
  logic [LW-1:0] lat_cnt;
  logic          auto_step;
  logic          eff_next;
  logic          step_one;
  logic [9:0]    step_addr;

`ifdef MEM_INSPECTOR_AUTOSCAN_EN
  localparam logic [26:0] SCAN_LAST = 27'd99_999_999;
  logic [26:0] scan_cnt;

  // Restarts on any button step so a manual step always gets a full dwell period
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (state != SHOW || !halted || step_next || step_prev || scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign auto_step = (state == SHOW) && (scan_cnt == SCAN_LAST);
`else
  assign auto_step = 1'b0;
`endif

  assign eff_next = step_next | auto_step;
  assign step_one = eff_next ^ step_prev;

  always_comb begin
    step_addr = addr_r;
    if (eff_next) step_addr = (addr_r == ADDR_TOP) ? 10'd0 : addr_r + 10'd1;
    else          step_addr = (addr_r == 10'd0) ? ADDR_TOP : addr_r - 10'd1;
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      infer_r    <= 1'b0;
      addr_r     <= '0;
      data_valid <= 1'b0;
      shown_word <= '0;
      lat_cnt    <= '0;
    end else if (!halted) begin
      // Address and last word survive a resume so the view is unchanged on the next halt
      state      <= IDLE;
      infer_r    <= 1'b0;
      data_valid <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          infer_r <= 1'b1;
          lat_cnt <= '0;
        end
        REQ: begin
          if (lat_cnt == LAT_LAST) state <= CAPTURE;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        CAPTURE: begin
          shown_word <= rd.infer_data;
          data_valid <= 1'b1;
          infer_r    <= 1'b0;
          state      <= SHOW;
        end
        SHOW: begin
          if (step_one) begin
            addr_r     <= step_addr;
            data_valid <= 1'b0;
            infer_r    <= 1'b1;
            lat_cnt    <= '0;
            state      <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd.infer      = infer_r;
  assign rd.infer_addr = addr_r;

  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              digit;
  logic [15:0]             half_word;
  logic [3:0]              nibble;

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) refresh <= '0;
    else        refresh <= refresh + 1'b1;
  end

  assign digit     = refresh[REFRESH_BITS-1 -: 2];
  assign half_word = sw_half ? shown_word[31:16] : shown_word[15:0];
  assign nibble    = half_word[{digit, 2'b00} +: 4];

  always_comb begin
    Anode_Activate = 4'b1111;
    Anode_Activate[digit] = 1'b0;
  end

  always_comb begin
    LED_out = 7'b1111111;
    case (nibble)
      4'h0: LED_out = 7'b0000001;
      4'h1: LED_out = 7'b1001111;
      4'h2: LED_out = 7'b0010010;
      4'h3: LED_out = 7'b0000110;
      4'h4: LED_out = 7'b1001100;
      4'h5: LED_out = 7'b0100100;
      4'h6: LED_out = 7'b0100000;
      4'h7: LED_out = 7'b0001111;
      4'h8: LED_out = 7'b0000000;
      4'h9: LED_out = 7'b0000100;
      4'hA: LED_out = 7'b0001000;
      4'hB: LED_out = 7'b1100000;
      4'hC: LED_out = 7'b0110001;
      4'hD: LED_out = 7'b1000010;
      4'hE: LED_out = 7'b0110000;
      4'hF: LED_out = 7'b0111000;
      default: LED_out = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_mem_inspector.sv
// Scoreboarded bench for mem_inspector: expected reads/captures are queued by stimulus and retired by a monitor.
module tb_mem_inspector;

  logic       fast_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       halted   = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       sw_half  = 1'b0;
  logic       data_valid;
  logic [6:0] LED_out;
  logic [3:0] Anode_Activate;

  mem_inspector_if bus ();

  mem_inspector #(
    .DEBOUNCE_CYCLES(4),
    .READ_LATENCY(2),
    .REFRESH_BITS(4),
    .ADDR_MAX(1023)
  ) dut (
    .fast_clk(fast_clk),
    .rst_n(rst_n),
    .halted(halted),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .sw_half(sw_half),
    .rd(bus.master),
    .data_valid(data_valid),
    .LED_out(LED_out),
    .Anode_Activate(Anode_Activate)
  );

  always #5 fast_clk = ~fast_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0]  exp_reads [$];
  logic [41:0] exp_caps  [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    case (a)
      10'd0:    mem_word = 32'hA1F0_0008;
      10'd1:    mem_word = 32'h8888_1111;
      10'd1023: mem_word = 32'hFFFF_A0A0;
      default:  mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h8: seg7 = 7'b0000000;
      4'hA: seg7 = 7'b0001000;
      4'hF: seg7 = 7'b0111000;
      default: seg7 = 7'bxxxxxxx;
    endcase
  endfunction

  // Two-stage memory: data appears two edges after the launch, zero when no read is active
  logic [31:0] mem_p1 = '0;
  initial bus.infer_data = '0;
  always @(posedge fast_clk) begin
    mem_p1         <= bus.infer ? mem_word(bus.infer_addr) : 32'h0;
    bus.infer_data <= mem_p1;
  end

  logic inf_q = 1'b0;
  logic dv_q  = 1'b0;
  int   inf_run = 0;

  always @(negedge fast_clk) begin
    if (!rst_n) begin
      inf_q   = 1'b0;
      dv_q    = 1'b0;
      inf_run = 0;
    end else begin
      if (bus.infer) inf_run++;
      if (bus.infer && !inf_q) begin
        inf_run = 1;
        if (exp_reads.size() == 0) begin
          check("unexpected_read", 32'(bus.infer_addr), 32'hFFFF_FFFF);
        end else begin
          check("read_addr", 32'(bus.infer_addr), 32'(exp_reads.pop_front()));
        end
      end
      if (data_valid && !dv_q) begin
        check("infer_high_cycles", inf_run, 3);
        check("infer_low_at_valid", 32'(bus.infer), 0);
        if (exp_caps.size() == 0) begin
          check("unexpected_capture", 32'(bus.infer_addr), 32'hFFFF_FFFF);
        end else begin
          logic [41:0] e;
          e = exp_caps.pop_front();
          check("cap_addr", 32'(bus.infer_addr), 32'(e[41:32]));
          check("cap_word", dut.shown_word, e[31:0]);
        end
      end
      inf_q = bus.infer;
      dv_q  = data_valid;
    end
  end

  task automatic expect_read(input logic [9:0] a, input bit cap);
    exp_reads.push_back(a);
    if (cap) exp_caps.push_back({a, mem_word(a)});
  endtask

  task automatic wait_sb(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_reads.size() == 0 && exp_caps.size() == 0) break;
      @(negedge fast_clk);
    end
    check("sb_drained", exp_reads.size() + exp_caps.size(), 0);
  endtask

  task automatic press(input bit nxt, input bit prv, input int cycles);
    @(negedge fast_clk);
    btn_next = nxt;
    btn_prev = prv;
    repeat (cycles) @(negedge fast_clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (12) @(negedge fast_clk);
  endtask

  task automatic check_disp(input logic [15:0] exp_half, input bit half);
    int d;
    sw_half = half;
    for (int k = 0; k < 16; k++) begin
      @(negedge fast_clk);
      case (Anode_Activate)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      check("anode_valid", 32'(d >= 0), 1);
      if (d >= 0) check("digit_seg", 32'(LED_out), 32'(seg7(exp_half[d*4 +: 4])));
    end
  endtask

  initial begin
    logic [3:0] anode_tbl [4];
    anode_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    repeat (10) @(negedge fast_clk);
    check("rst_infer", 32'(bus.infer), 0);
    check("rst_addr", 32'(bus.infer_addr), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_anode", 32'(Anode_Activate), 32'(4'b1110));
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      check("idle_anode", 32'(Anode_Activate), 32'(anode_tbl[(k / 4) % 4]));
      check("idle_led", 32'(LED_out), 32'(7'b0000001));
      check("idle_infer", 32'(bus.infer), 0);
      @(negedge fast_clk);
      #1;
    end

    // First read after halt
    expect_read(10'd0, 1'b1);
    halted = 1'b1;
    wait_sb(20);
    check_disp(16'h0008, 1'b0);
    check_disp(16'hA1F0, 1'b1);
    sw_half = 1'b0;

    // Glitch shorter than the debounce window
    press(1'b1, 1'b0, 3);
    repeat (5) @(negedge fast_clk);
    check("glitch_addr", 32'(bus.infer_addr), 0);
    check("glitch_valid", 32'(data_valid), 1);

    expect_read(10'd1, 1'b1);
    press(1'b1, 1'b0, 10);
    wait_sb(40);

    expect_read(10'd0, 1'b1);
    press(1'b0, 1'b1, 10);
    wait_sb(40);

    expect_read(10'd1023, 1'b1);
    press(1'b0, 1'b1, 10);
    wait_sb(40);
    check("wrap_down_addr", 32'(bus.infer_addr), 1023);
    check_disp(16'hFFFF, 1'b1);
    sw_half = 1'b0;

    expect_read(10'd0, 1'b1);
    press(1'b1, 1'b0, 10);
    wait_sb(40);
    check("wrap_up_addr", 32'(bus.infer_addr), 0);

    // Simultaneous presses cancel
    press(1'b1, 1'b1, 10);
    repeat (5) @(negedge fast_clk);
    check("both_addr", 32'(bus.infer_addr), 0);
    check("both_valid", 32'(data_valid), 1);

    // Reset while the read to address 1 is in flight
    expect_read(10'd1, 1'b0);
    @(negedge fast_clk);
    btn_next = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.infer) break;
      @(negedge fast_clk);
    end
    check("midread_reached_req", 32'(bus.infer), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_infer", 32'(bus.infer), 0);
    check("async_valid", 32'(data_valid), 0);
    check("async_addr", 32'(bus.infer_addr), 0);
    btn_next = 1'b0;
    expect_read(10'd0, 1'b1);
    repeat (3) @(negedge fast_clk);
    rst_n = 1'b1;
    wait_sb(40);
    check_disp(16'h0008, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d, expected completion", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
